// File: rtl/otter_io_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: register offsets and field positions.
package otter_io_pkg;

  localparam logic [4:0] TMR_CTRL_OFS  = 5'h00;
  localparam logic [4:0] TMR_PRESC_OFS = 5'h04;
  localparam logic [4:0] TMR_CMP_OFS   = 5'h08;
  localparam logic [4:0] TMR_CNT_OFS   = 5'h0C;
  localparam logic [4:0] TMR_STAT_OFS  = 5'h10;

  localparam int unsigned TMR_CTRL_EN_BIT   = 0;
  localparam int unsigned TMR_CTRL_AUTO_BIT = 1;
  localparam int unsigned TMR_CTRL_IRQ_BIT  = 2;
  localparam int unsigned TMR_STAT_PEND_BIT = 0;

  // Byte offset within a 32-byte window with the sub-word bits dropped.
  function automatic logic [4:0] tmr_word_ofs(input logic [31:0] addr);
    return {addr[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Free-running prescaler: emits one tick every PRESCALE+1 enabled cycles.
module timer_prescaler #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_clr,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_pcnt;
  logic [PRESCALE_W-1:0] w_pcnt_d;

  always_comb begin
    o_tick   = i_en && (r_pcnt == i_prescale);
    w_pcnt_d = r_pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    if (!i_en || i_clr || o_tick) begin
      w_pcnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= w_pcnt_d;
    end
  end

endmodule

// File: rtl/iobus_timer.sv
// IOBUS timer peripheral: register window, compare/reload logic and level interrupt.
module iobus_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_IN,
  output logic        INT
);

  logic                  w_hit;
  logic [4:0]            w_ofs;
  logic                  w_wr_ctrl, w_wr_presc, w_wr_cmp, w_wr_cnt, w_wr_stat;
  logic                  w_presc_clr;
  logic                  w_tick;
  logic                  w_match;
  logic [31:0]           w_count_d;
  logic                  w_pend_d;

  logic                  r_en, r_auto, r_irq_en;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [31:0]           r_compare;
  logic [31:0]           r_count;
  logic                  r_pend;
  logic                  r_int;

  always_comb begin
    w_hit       = IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
    w_ofs       = tmr_word_ofs(IOBUS_ADDR);
    w_wr_ctrl   = IOBUS_WR && w_hit && (w_ofs == TMR_CTRL_OFS);
    w_wr_presc  = IOBUS_WR && w_hit && (w_ofs == TMR_PRESC_OFS);
    w_wr_cmp    = IOBUS_WR && w_hit && (w_ofs == TMR_CMP_OFS);
    w_wr_cnt    = IOBUS_WR && w_hit && (w_ofs == TMR_CNT_OFS);
    w_wr_stat   = IOBUS_WR && w_hit && (w_ofs == TMR_STAT_OFS);
    w_presc_clr = w_wr_presc || (w_wr_ctrl && !IOBUS_OUT[TMR_CTRL_EN_BIT]);
  end

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .i_clk      (CLK),
    .i_rst_n    (RST_N),
    .i_en       (r_en),
    .i_prescale (r_prescale),
    .i_clr      (w_presc_clr),
    .o_tick     (w_tick)
  );

  // A software COUNT write suppresses the match check; a match beats a same-cycle W1C.
  always_comb begin
    w_match   = w_tick && !w_wr_cnt && (r_count == r_compare);
    w_count_d = r_count;
    if (w_wr_cnt) begin
      w_count_d = IOBUS_OUT;
    end else if (w_match && r_auto) begin
      w_count_d = '0;
    end else if (w_tick) begin
      w_count_d = r_count + 32'd1;
    end
    w_pend_d = r_pend;
    if (w_wr_stat && IOBUS_OUT[TMR_STAT_PEND_BIT]) begin
      w_pend_d = 1'b0;
    end
    if (w_match) begin
      w_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_en       <= 1'b0;
      r_auto     <= 1'b0;
      r_irq_en   <= 1'b0;
      r_prescale <= '0;
      r_compare  <= '0;
      r_count    <= '0;
      r_pend     <= 1'b0;
      r_int      <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= IOBUS_OUT[TMR_CTRL_EN_BIT];
        r_auto   <= IOBUS_OUT[TMR_CTRL_AUTO_BIT];
        r_irq_en <= IOBUS_OUT[TMR_CTRL_IRQ_BIT];
      end
      if (w_wr_presc) begin
        r_prescale <= IOBUS_OUT[PRESCALE_W-1:0];
      end
      if (w_wr_cmp) begin
        r_compare <= IOBUS_OUT;
      end
      r_count <= w_count_d;
      r_pend  <= w_pend_d;
      r_int   <= r_pend & r_irq_en;
    end
  end

  always_comb begin
    IOBUS_IN = '0;
    if (w_hit) begin
      case (w_ofs)
        TMR_CTRL_OFS: begin
          IOBUS_IN[TMR_CTRL_EN_BIT]   = r_en;
          IOBUS_IN[TMR_CTRL_AUTO_BIT] = r_auto;
          IOBUS_IN[TMR_CTRL_IRQ_BIT]  = r_irq_en;
        end
        TMR_PRESC_OFS: IOBUS_IN[PRESCALE_W-1:0] = r_prescale;
        TMR_CMP_OFS:   IOBUS_IN = r_compare;
        TMR_CNT_OFS:   IOBUS_IN = r_count;
        TMR_STAT_OFS:  IOBUS_IN[TMR_STAT_PEND_BIT] = r_pend;
        default:       IOBUS_IN = '0;
      endcase
    end
  end

  assign INT = r_int;

endmodule

// File: tb/tb_iobus_timer.sv
// Randomised and directed bench for iobus_timer against a tick-schedule reference model.
module tb_iobus_timer;

  localparam logic [31:0] BASE  = 32'h1100_0100;
  localparam logic [31:0] PMASK = 32'h0000_FFFF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] IOBUS_ADDR = BASE;
  logic [31:0] IOBUS_OUT = '0;
  logic        IOBUS_WR = 1'b0;
  logic [31:0] IOBUS_IN;
  logic        INT;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  iobus_timer #(
    .BASE_ADDR  (BASE),
    .PRESCALE_W (16)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_IN   (IOBUS_IN),
    .INT        (INT)
  );

  always #5 CLK = ~CLK;

  // Reference state: the prescaler is modelled as the absolute cycle of the next tick.
  logic        m_en = 0, m_auto = 0, m_irq = 0, m_pend = 0, m_int = 0;
  logic [31:0] m_presc = 0, m_cmp = 0, m_count = 0;
  longint      m_cyc = 0, m_tick_cyc = 0;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [4:0] o;
    o = a[4:0] & 5'h1C;
    if (a[31:5] != BASE[31:5]) return 32'd0;
    case (o)
      5'h00:   return {29'd0, m_irq, m_auto, m_en};
      5'h04:   return m_presc;
      5'h08:   return m_cmp;
      5'h0C:   return m_count;
      5'h10:   return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic       wr, tick, match, restart, wcnt;
    logic [4:0] o;
    logic [31:0] d;
    o    = IOBUS_ADDR[4:0] & 5'h1C;
    d    = IOBUS_OUT;
    wr   = IOBUS_WR && (IOBUS_ADDR[31:5] == BASE[31:5]);
    wcnt = wr && (o == 5'h0C);
    if (!RST_N) begin
      {m_en, m_auto, m_irq, m_pend, m_int} = '0;
      m_presc = 0; m_cmp = 0; m_count = 0;
      m_tick_cyc = m_cyc + 1;
    end else begin
      tick    = m_en && (m_cyc == m_tick_cyc);
      match   = tick && !wcnt && (m_count == m_cmp);
      restart = !m_en || tick || (wr && o == 5'h04) || (wr && o == 5'h00 && !d[0]);
      m_int   = m_pend && m_irq;
      if (wcnt) m_count = d;
      else if (tick) m_count = (match && m_auto) ? 32'd0 : m_count + 32'd1;
      if (wr && o == 5'h10 && d[0]) m_pend = 1'b0;
      if (match) m_pend = 1'b1;
      if (wr && o == 5'h00) {m_irq, m_auto, m_en} = d[2:0];
      if (wr && o == 5'h04) m_presc = d & PMASK;
      if (wr && o == 5'h08) m_cmp = d;
      if (restart) m_tick_cyc = m_cyc + 1 + longint'(m_presc);
    end
    m_cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("model_rdata", IOBUS_IN, m_read(IOBUS_ADDR));
      chk("model_int", {31'd0, INT}, {31'd0, m_int});
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic wr(input logic [4:0] o, input logic [31:0] d);
    IOBUS_ADDR = BASE + {27'd0, o};
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    cyc();
    IOBUS_WR   = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    IOBUS_ADDR = a;
    IOBUS_WR   = 1'b0;
    #4;
    chk(name, IOBUS_IN, exp);
    cyc();
  endtask

  task automatic wait_int(input int bound, output int n);
    n = 1;
    while (!INT && n <= bound) begin
      cyc();
      n++;
    end
    chk("int_timeout", {31'd0, INT}, 32'd1);
  endtask

  initial begin
    int n;
    longint t1, t2;
    logic [4:0] o;
    logic [31:0] d;

    // Reset and readback
    cyc();
    cyc();
    RST_N  = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_chk("reset_read", BASE + 32'(i * 4), 32'd0);
    end
    rd_chk("miss_read", BASE + 32'h20, 32'd0);
    chk("reset_int", {31'd0, INT}, 32'd0);

    // Periodic interrupt
    wr(5'h04, 32'd3);
    wr(5'h08, 32'd4);
    wr(5'h0C, 32'd0);
    wr(5'h00, 32'd7);
    wait_int(100, n);
    chk("first_int_latency", 32'(n), 32'd22);
    t1 = m_cyc;
    wr(5'h10, 32'd1);
    chk("int_after_w1c_edge", {31'd0, INT}, 32'd1);
    cyc();
    chk("int_cleared", {31'd0, INT}, 32'd0);
    wait_int(100, n);
    t2 = m_cyc;
    chk("int_period", 32'(t2 - t1), 32'd20);

    // One-shot with wrap
    wr(5'h00, 32'd0);
    wr(5'h10, 32'd1);
    wr(5'h04, 32'd0);
    wr(5'h08, 32'd1);
    wr(5'h0C, 32'hFFFF_FFFE);
    wr(5'h00, 32'd1);
    rd_chk("wrap_cnt0", BASE + 32'h0C, 32'hFFFF_FFFE);
    rd_chk("wrap_cnt1", BASE + 32'h0C, 32'hFFFF_FFFF);
    rd_chk("wrap_cnt2", BASE + 32'h0C, 32'h0000_0000);
    rd_chk("wrap_cnt3", BASE + 32'h0C, 32'h0000_0001);
    rd_chk("wrap_cnt4", BASE + 32'h0C, 32'h0000_0002);
    rd_chk("oneshot_pend", BASE + 32'h10, 32'd1);
    wr(5'h10, 32'd1);
    repeat (30) cyc();
    rd_chk("oneshot_no_repeat", BASE + 32'h10, 32'd0);

    // Collisions: COUNT write beats tick, match beats W1C
    wr(5'h0C, 32'h10);
    rd_chk("cnt_write_wins", BASE + 32'h0C, 32'h10);
    wr(5'h00, 32'd0);
    wr(5'h10, 32'd1);
    wr(5'h04, 32'd0);
    wr(5'h08, 32'h20);
    wr(5'h0C, 32'h1E);
    wr(5'h00, 32'd3);
    cyc();
    cyc();
    wr(5'h10, 32'd1);
    rd_chk("match_beats_w1c", BASE + 32'h10, 32'd1);

    // Masking
    wr(5'h00, 32'd1);
    cyc();
    chk("masked_int", {31'd0, INT}, 32'd0);
    wr(5'h00, 32'd5);
    chk("unmask_int_wait", {31'd0, INT}, 32'd0);
    cyc();
    chk("unmask_int", {31'd0, INT}, 32'd1);

    // Reset mid-count
    wr(5'h04, 32'd0);
    wr(5'h08, 32'h60);
    wr(5'h0C, 32'h55);
    wr(5'h00, 32'd7);
    repeat (3) cyc();
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    rd_chk("rst_cnt", BASE + 32'h0C, 32'd0);
    rd_chk("rst_ctrl", BASE + 32'h00, 32'd0);
    rd_chk("rst_stat", BASE + 32'h10, 32'd0);
    chk("rst_int", {31'd0, INT}, 32'd0);
    repeat (100) cyc();
    chk("rst_no_spurious", {31'd0, INT}, 32'd0);

    // Randomised traffic, checked every cycle by the compare process
    for (int k = 0; k < 1500; k++) begin
      n = $urandom_range(0, 99);
      if (n < 2) begin
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
      end else if (n < 35) begin
        o = {$urandom_range(0, 7), 2'b00};
        case (o)
          5'h04:   d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 3));
          5'h08:   d = 32'($urandom_range(0, 6));
          5'h0C:   d = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                   : 32'($urandom_range(0, 6));
          default: d = $urandom;
        endcase
        IOBUS_ADDR = BASE + {27'd0, o} + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) IOBUS_ADDR = IOBUS_ADDR ^ 32'h0000_1000;
        IOBUS_OUT = d;
        IOBUS_WR  = 1'b1;
        cyc();
        IOBUS_WR  = 1'b0;
      end else begin
        IOBUS_ADDR = BASE + 32'($urandom_range(0, 39));
        cyc();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
    $fatal(1);
  end

endmodule
